// File: rtl/slice_seq_alu.sv
// slice_seq_alu: slice-serial ALU stage downstream of the operand arranger.
// Takes one arranged operand pair, processes one S-bit slice per clock in
// arranged order, and presents the result in natural slice order together
// with carry/zero/lt flags on a valid/ready output.
//
// Optional build macro: SLICE_SEQ_ALU_OVF_EN adds the out_ovf port
// (signed overflow for ADD/SUB with LSB-first arrangement).
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for an operand pair, in_ready=1
// RUN     | processing slice idx on every edge
// DONE    | result and flags held, out_valid=1 until out_ready
module slice_seq_alu #(
    parameter int S   = 4,
    parameter int N_A = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_reverse,
    input  logic [N_A*S-1:0] in_a,
    input  logic [N_A*S-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_A*S-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_lt,
    output logic             busy
`ifdef SLICE_SEQ_ALU_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int W  = N_A * S;
    localparam int IW = (N_A > 1) ? $clog2(N_A) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_A - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;

    logic [1:0]    state;
    logic [2:0]    op_q;
    logic          rev_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  result_q;
    logic [IW-1:0] idx_q;
    logic          carry_q;
    logic          eq_q;
    logic          lt_q;

    logic [S-1:0]  a_s;
    logic [S-1:0]  b_s;
    logic [S-1:0]  b_eff;
    logic [S:0]    sum;
    logic [S-1:0]  slice_r;
    logic [IW-1:0] w_idx;
    logic          is_last;
    logic          is_arith;
    logic          slice_ne;

`ifdef SLICE_SEQ_ALU_OVF_EN
    logic          ovf_q;
    logic          carry_msb_in;
`endif

    // Slice datapath for the slice currently selected by idx.
    always_comb begin
        a_s      = a_q[idx_q*S +: S];
        b_s      = b_q[idx_q*S +: S];
        b_eff    = (op_q == OP_SUB) ? ~b_s : b_s;
        sum      = {1'b0, a_s} + {1'b0, b_eff} + {{S{1'b0}}, carry_q};
        is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
        is_last  = (idx_q == LAST_IDX);
        slice_ne = (a_s != b_s);
        // With MSB-first arrangement, processing slice idx lands at the mirrored position.
        w_idx    = rev_q ? (LAST_IDX - idx_q) : idx_q;
        case (op_q)
            OP_ADD, OP_SUB: slice_r = sum[S-1:0];
            OP_AND:         slice_r = a_s & b_s;
            OP_OR:          slice_r = a_s | b_s;
            OP_XOR:         slice_r = a_s ^ b_s;
            OP_CMP:         slice_r = '0;
            default:        slice_r = a_s;
        endcase
    end

`ifdef SLICE_SEQ_ALU_OVF_EN
    // Carry into the top bit recovered from the sum bit: s = a ^ b ^ cin.
    always_comb begin
        carry_msb_in = sum[S-1] ^ a_s[S-1] ^ b_eff[S-1];
    end
`endif

    // Control FSM and slice-serial accumulation of result and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= OP_ADD;
            rev_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
`ifdef SLICE_SEQ_ALU_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q     <= in_op;
                        rev_q    <= in_reverse;
                        a_q      <= in_a;
                        b_q      <= in_b;
                        result_q <= '0;
                        idx_q    <= '0;
                        carry_q  <= (in_op == OP_SUB);
                        eq_q     <= 1'b1;
                        lt_q     <= 1'b0;
`ifdef SLICE_SEQ_ALU_OVF_EN
                        ovf_q    <= 1'b0;
`endif
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    idx_q <= idx_q + 1'b1;
                    result_q[w_idx*S +: S] <= slice_r;
                    if (is_arith) begin
                        carry_q <= sum[S];
                    end
`ifdef SLICE_SEQ_ALU_OVF_EN
                    if (is_arith && !rev_q && is_last) begin
                        ovf_q <= carry_msb_in ^ sum[S];
                    end
`endif
                    if (is_last) begin
                        state <= ST_DONE;
                    end
                    if ((op_q == OP_CMP) && slice_ne) begin
                        eq_q <= 1'b0;
                        lt_q <= (a_s < b_s);
                        // MSB-first: the first differing slice already decides the order.
                        if (rev_q) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake and flag outputs; flags only assert while the result is presented.
    always_comb begin
        in_ready   = (state == ST_IDLE);
        busy       = (state != ST_IDLE);
        out_valid  = (state == ST_DONE);
        out_result = result_q;
        out_carry  = out_valid && is_arith && carry_q;
        out_zero   = out_valid && ((op_q == OP_CMP) ? eq_q : (result_q == '0));
        out_lt     = out_valid && (op_q == OP_CMP) && lt_q;
`ifdef SLICE_SEQ_ALU_OVF_EN
        out_ovf    = out_valid && ovf_q;
`endif
    end

endmodule

// File: tb/tb_slice_seq_alu.sv
// Testbench for slice_seq_alu (S=4, N_A=2): directed vectors, randomized
// operations against a behavioural model, backpressure, mid-run reset and
// back-to-back operation. Honours SLICE_SEQ_ALU_OVF_EN for out_ovf.
module tb_slice_seq_alu;

    localparam int S   = 4;
    localparam int N_A = 2;
    localparam int W   = N_A * S;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic         in_reverse;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_carry;
    logic         out_zero;
    logic         out_lt;
    logic         busy;
    logic         ovf_obs;

    int checks   = 0;
    int failures = 0;

    slice_seq_alu #(.S(S), .N_A(N_A)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_reverse (in_reverse),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_zero   (out_zero),
        .out_lt     (out_lt),
        .busy       (busy)
`ifdef SLICE_SEQ_ALU_OVF_EN
        ,
        .out_ovf    (ovf_obs)
`endif
    );

`ifndef SLICE_SEQ_ALU_OVF_EN
    assign ovf_obs = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         lt;
        logic         ovf;
        int           lat;
    } exp_t;

    typedef struct {
        logic [2:0]   op;
        logic         rev;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         lt;
        logic         ovf;
        int           lat;
    } vec_t;

    // Reference: operate on natural-order values; only reversed ADD/SUB
    // needs the slice-ordered carry chain because that result is defined so.
    function automatic exp_t model(input logic [2:0] op, input logic rev,
                                   input logic [W-1:0] ia, input logic [W-1:0] ib);
        exp_t e;
        logic [W-1:0] na;
        logic [W-1:0] nb;
        logic [S:0]   t;
        logic [S-1:0] bs;
        logic         c;
        int           k;
        na = ia;
        nb = ib;
        if (rev) begin
            for (int i = 0; i < N_A; i++) begin
                na[i*S +: S] = ia[(N_A-1-i)*S +: S];
                nb[i*S +: S] = ib[(N_A-1-i)*S +: S];
            end
        end
        e.res = '0; e.c = 1'b0; e.lt = 1'b0; e.ovf = 1'b0; e.lat = N_A;
        case (op)
            3'd0, 3'd1: begin
                if (!rev) begin
                    if (op == 3'd0) begin
                        {e.c, e.res} = {1'b0, na} + {1'b0, nb};
                        e.ovf = (na[W-1] == nb[W-1]) && (e.res[W-1] != na[W-1]);
                    end else begin
                        e.res = na - nb;
                        e.c   = (na >= nb);
                        e.ovf = (na[W-1] != nb[W-1]) && (e.res[W-1] != na[W-1]);
                    end
                end else begin
                    c = (op == 3'd1);
                    for (int i = 0; i < N_A; i++) begin
                        bs = (op == 3'd1) ? ~ib[i*S +: S] : ib[i*S +: S];
                        t  = {1'b0, ia[i*S +: S]} + {1'b0, bs} + {{S{1'b0}}, c};
                        e.res[(N_A-1-i)*S +: S] = t[S-1:0];
                        c = t[S];
                    end
                    e.c = c;
                end
            end
            3'd2: e.res = na & nb;
            3'd3: e.res = na | nb;
            3'd4: e.res = na ^ nb;
            3'd5: begin
                e.lt = (na < nb);
                if (rev) begin
                    k = N_A;
                    for (int i = N_A - 1; i >= 0; i--)
                        if (ia[i*S +: S] != ib[i*S +: S]) k = i;
                    e.lat = (k == N_A) ? N_A : k + 1;
                end
            end
            default: e.res = na;
        endcase
        e.z = (op == 3'd5) ? (na == nb) : (e.res == '0);
        return e;
    endfunction

    // Drive one operand pair and wait for out_valid; lat = edges after acceptance, -1 on timeout.
    task automatic run_op(input logic [2:0] op, input logic rev,
                          input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b1; in_op = op; in_reverse = rev; in_a = a; in_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op = 3'($urandom); in_reverse = 1'($urandom);
        in_a = W'($urandom); in_b = W'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
        end
        checks++;
        if (out_result !== '0 || out_carry !== 1'b0 || out_zero !== 1'b0 || out_lt !== 1'b0 || ovf_obs !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: result=%h c=%b z=%b lt=%b ovf=%b, required all zero",
                     out_result, out_carry, out_zero, out_lt, ovf_obs);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        vec_t v[13];
        int   lat;
        v[0]  = '{3'd0, 1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        v[1]  = '{3'd1, 1'b0, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        v[2]  = '{3'd1, 1'b0, 8'h01, 8'h10, 8'hF1, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        v[3]  = '{3'd1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 2};
        v[4]  = '{3'd5, 1'b1, 8'h25, 8'h37, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        v[5]  = '{3'd5, 1'b0, 8'h52, 8'h73, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        v[6]  = '{3'd5, 1'b0, 8'h99, 8'h99, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        v[7]  = '{3'd5, 1'b1, 8'h99, 8'h99, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        v[8]  = '{3'd4, 1'b1, 8'hA5, 8'h3C, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        v[9]  = '{3'd4, 1'b0, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        v[10] = '{3'd6, 1'b1, 8'hA5, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        v[11] = '{3'd2, 1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        v[12] = '{3'd0, 1'b1, 8'h18, 8'h0F, 8'h72, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        for (int i = 0; i < 13; i++) begin
            run_op(v[i].op, v[i].rev, v[i].a, v[i].b, lat);
            checks++;
            if (lat != v[i].lat) begin
                failures++;
                $display("FAIL dir%0d_latency: got %0d, required %0d", i, lat, v[i].lat);
            end
            checks++;
            if (out_result !== v[i].res || out_carry !== v[i].c || out_zero !== v[i].z || out_lt !== v[i].lt) begin
                failures++;
                $display("FAIL dir%0d_result: result=%h c=%b z=%b lt=%b, required %h %b %b %b",
                         i, out_result, out_carry, out_zero, out_lt, v[i].res, v[i].c, v[i].z, v[i].lt);
            end
`ifdef SLICE_SEQ_ALU_OVF_EN
            checks++;
            if (ovf_obs !== v[i].ovf) begin
                failures++;
                $display("FAIL dir%0d_ovf: got %b, required %b", i, ovf_obs, v[i].ovf);
            end
`endif
            pop();
        end
    endtask

    task automatic test_random();
        logic [2:0]   op;
        logic         rev;
        logic [W-1:0] a;
        logic [W-1:0] b;
        exp_t         e;
        int           lat;
        for (int n = 0; n < 200; n++) begin
            op  = 3'($urandom_range(0, 7));
            rev = 1'($urandom);
            a   = W'($urandom);
            b   = W'($urandom);
            case ($urandom_range(0, 5))
                0: b = a;
                1: b[S-1:0] = a[S-1:0];
                2: b[W-1:W-S] = a[W-1:W-S];
                default: ;
            endcase
            e = model(op, rev, a, b);
            run_op(op, rev, a, b, lat);
            checks++;
            if (lat != e.lat || out_result !== e.res || out_carry !== e.c || out_zero !== e.z ||
                out_lt !== e.lt) begin
                failures++;
                $display("FAIL rand%0d op=%0d rev=%b a=%h b=%h: lat=%0d res=%h c=%b z=%b lt=%b, required lat=%0d res=%h c=%b z=%b lt=%b",
                         n, op, rev, a, b, lat, out_result, out_carry, out_zero, out_lt,
                         e.lat, e.res, e.c, e.z, e.lt);
            end
`ifdef SLICE_SEQ_ALU_OVF_EN
            checks++;
            if (ovf_obs !== e.ovf) begin
                failures++;
                $display("FAIL rand%0d_ovf op=%0d rev=%b a=%h b=%h: got %b, required %b",
                         n, op, rev, a, b, ovf_obs, e.ovf);
            end
`endif
            pop();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(3'd0, 1'b0, 8'h3C, 8'h0F, lat);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_op = 3'd4; in_a = 8'hFF; in_b = 8'h11;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 8'h4B ||
                out_carry !== 1'b0 || out_zero !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d: valid=%b in_ready=%b res=%h c=%b z=%b, required 1 0 4b 0 0",
                         i, out_valid, in_ready, out_result, out_carry, out_zero);
            end
        end
        in_valid = 1'b0;
        pop();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        run_op(3'd3, 1'b0, 8'hF0, 8'h0C, lat);
        checks++;
        if (lat != 2 || out_result !== 8'hFC) begin
            failures++;
            $display("FAIL bp_next: lat=%0d res=%h, required 2 fc", lat, out_result);
        end
        pop();
    endtask

    task automatic test_midrun_reset();
        int lat;
        in_valid = 1'b1; in_op = 3'd0; in_reverse = 1'b0; in_a = 8'hFF; in_b = 8'h01;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_result !== '0 ||
            out_carry !== 1'b0 || out_zero !== 1'b0 || out_lt !== 1'b0) begin
            failures++;
            $display("FAIL midrun_rst: in_ready=%b valid=%b busy=%b res=%h c=%b z=%b lt=%b, required 1 0 0 00 0 0 0",
                     in_ready, out_valid, busy, out_result, out_carry, out_zero, out_lt);
        end
        run_op(3'd0, 1'b0, 8'h01, 8'h01, lat);
        checks++;
        if (lat != 2 || out_result !== 8'h02 || out_carry !== 1'b0 || out_zero !== 1'b0) begin
            failures++;
            $display("FAIL midrun_next: lat=%0d res=%h c=%b z=%b, required 2 02 0 0",
                     lat, out_result, out_carry, out_zero);
        end
        pop();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        exp_t         e;
        int           lat;
        out_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            a = W'($urandom);
            b = W'($urandom);
            e = model(3'd1, 1'b0, a, b);
            run_op(3'd1, 1'b0, a, b, lat);
            checks++;
            if (lat != 2 || out_result !== e.res || out_carry !== e.c) begin
                failures++;
                $display("FAIL b2b%0d a=%h b=%h: lat=%0d res=%h c=%b, required 2 %h %b",
                         n, a, b, lat, out_result, out_carry, e.res, e.c);
            end
            @(posedge clk); #1;
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL b2b%0d_ready: in_ready=%b out_valid=%b, required 1 0", n, in_ready, out_valid);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_reverse = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_midrun_reset();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
